// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto one single-port memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
//
// state  | meaning
// IDLE   | no access in flight, mem_ce low
// BUSY_I | fetch access presented to memory, waiting for mem_ready
// BUSY_D | data access presented to memory, waiting for mem_ready
module mem_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            i_req_i,
    input  logic [AW-1:0]   i_addr_i,
    output logic            i_ack_o,
    output logic [DW-1:0]   i_rdata_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [AW-1:0]   d_addr_i,
    input  logic [DW-1:0]   d_wdata_i,
    input  logic [DW/8-1:0] d_sel_i,
    output logic            d_ack_o,
    output logic [DW-1:0]   d_rdata_o,
    output logic            mem_ce_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_sel_o,
    input  logic [DW-1:0]   mem_rdata_i,
    input  logic            mem_ready_i,
    output logic            stall_req_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e            state_q;
    logic              mem_ce_q;
    logic              mem_we_q;
    logic [AW-1:0]     mem_addr_q;
    logic [DW-1:0]     mem_wdata_q;
    logic [DW/8-1:0]   mem_sel_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic [DW-1:0]     i_rdata_q;
    logic [DW-1:0]     d_rdata_q;
`ifdef MEM_ARB_RR_EN
    logic              last_d_q;
`endif

    logic i_done, d_done, arb_pt;
    logic i_elig, d_elig;
    logic grant_i, grant_d;

    // A port whose access completes this cycle, or whose ack is out now, still
    // holds req high; it must not be granted again for that same request.
    always_comb begin
        i_done  = (state_q == BUSY_I) & mem_ready_i;
        d_done  = (state_q == BUSY_D) & mem_ready_i;
        arb_pt  = (state_q == IDLE) | i_done | d_done;
        i_elig  = i_req_i & ~i_ack_q & ~i_done;
        d_elig  = d_req_i & ~d_ack_q & ~d_done;
`ifdef MEM_ARB_RR_EN
        grant_d = arb_pt & d_elig & (~i_elig | ~last_d_q);
`else
        grant_d = arb_pt & d_elig;
`endif
        grant_i = arb_pt & i_elig & ~grant_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_sel_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            i_ack_q <= i_done;
            d_ack_q <= d_done;
            if (i_done) begin
                i_rdata_q <= mem_rdata_i;
            end
            if (d_done && !mem_we_q) begin
                d_rdata_q <= mem_rdata_i;
            end
            if (arb_pt) begin
                if (grant_d) begin
                    state_q     <= BUSY_D;
                    mem_ce_q    <= 1'b1;
                    mem_we_q    <= d_we_i;
                    mem_addr_q  <= d_addr_i;
                    mem_wdata_q <= d_wdata_i;
                    mem_sel_q   <= d_sel_i;
`ifdef MEM_ARB_RR_EN
                    last_d_q    <= 1'b1;
`endif
                end else if (grant_i) begin
                    state_q     <= BUSY_I;
                    mem_ce_q    <= 1'b1;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= i_addr_i;
                    mem_sel_q   <= '1;
`ifdef MEM_ARB_RR_EN
                    last_d_q    <= 1'b0;
`endif
                end else begin
                    state_q     <= IDLE;
                    mem_ce_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                end
            end
        end
    end

    assign i_ack_o     = i_ack_q;
    assign d_ack_o     = d_ack_q;
    assign i_rdata_o   = i_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_ce_o    = mem_ce_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_sel_o   = mem_sel_q;
    assign stall_req_o = (i_req_i & ~i_ack_q) | (d_req_i & ~d_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: requester and memory agents driven against a
// transaction-level reference of which request owns the memory each cycle.
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req, i_ack;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_sel, mem_sel;
    logic        mem_ce, mem_we, mem_ready, stall_req;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_ack_o(i_ack), .i_rdata_o(i_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_sel_i(d_sel), .d_ack_o(d_ack), .d_rdata_o(d_rdata),
        .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_sel_o(mem_sel), .mem_rdata_i(mem_rdata),
        .mem_ready_i(mem_ready), .stall_req_o(stall_req)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference: which request owns the memory (0 none, 1 fetch, 2 data) and what it asked for
    int          m_busy;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [3:0]  m_sel;
    logic        m_i_ack, m_d_ack;
    logic [31:0] m_i_rdata, m_d_rdata;
    bit          m_last_d;
    bit          i_granted, d_granted, i_drop, d_drop;

    // agent knobs
    int          i_prob = 0, d_prob = 0;
    bit          i_force = 0, d_force = 0;
    logic [31:0] f_i_addr, f_d_addr, f_d_wdata;
    logic        f_d_we;
    logic [3:0]  f_d_sel;
    int          w_lo = 0, w_hi = 0, w_cnt = -1;
    bit          rd_fixed = 0, stray = 0;
    logic [31:0] rd_val;
    int          i_ack_cyc = 0, d_ack_cyc = 0, d_ack_cnt = 0, ce_cnt = 0;
    int          t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_i_ack = 0; m_d_ack = 0; m_i_rdata = 0; m_d_rdata = 0;
        m_last_d = 0; m_addr = 0; m_wdata = 0; m_we = 0; m_sel = 0;
        i_req = 0; d_req = 0; i_granted = 0; d_granted = 0; i_drop = 0; d_drop = 0;
        i_force = 0; d_force = 0; w_cnt = -1; mem_ready = 0;
    endtask

    task automatic start_i();
        i_addr = i_force ? f_i_addr : ($urandom & 32'hFFFF_FFFC);
        i_force = 0; i_req = 1; i_granted = 0;
    endtask

    task automatic start_d();
        if (d_force) begin
            d_we = f_d_we; d_addr = f_d_addr; d_wdata = f_d_wdata; d_sel = f_d_sel;
        end else begin
            d_we = 1'($urandom_range(0, 1)); d_addr = $urandom & 32'hFFFF_FFFC;
            d_wdata = $urandom; d_sel = 4'($urandom_range(1, 15));
        end
        d_force = 0; d_req = 1; d_granted = 0;
    endtask

    // requesters hold req through their ack cycle, then drop or re-issue
    task automatic agent_step();
        if (i_req && m_i_ack) i_drop = 1;
        else begin
            if (i_drop) begin i_drop = 0; i_req = 0; end
            if (!i_req && (i_force || int'($urandom_range(0, 99)) < i_prob)) start_i();
        end
        if (d_req && m_d_ack) d_drop = 1;
        else begin
            if (d_drop) begin d_drop = 0; d_req = 0; end
            if (!d_req && (d_force || int'($urandom_range(0, 99)) < d_prob)) start_d();
        end
    endtask

    task automatic mem_step();
        if (m_busy != 0) begin
            if (w_cnt < 0) w_cnt = int'($urandom_range(w_hi, w_lo));
            if (w_cnt == 0) begin mem_ready = 1; w_cnt = -1; end
            else begin mem_ready = 0; w_cnt--; end
        end else begin
            mem_ready = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            w_cnt = -1;
        end
        mem_rdata = rd_fixed ? rd_val : $urandom;
    endtask

    task automatic model_step();
        bit ie, de, take_d, take_i, fin, n_i_ack, n_d_ack;
        fin     = (m_busy != 0) && mem_ready;
        n_i_ack = (m_busy == 1) && mem_ready;
        n_d_ack = (m_busy == 2) && mem_ready;
        if (n_i_ack) m_i_rdata = mem_rdata;
        if (n_d_ack && !m_we) m_d_rdata = mem_rdata;
        if (m_busy == 0 || fin) begin
            // a request may be served once; it stays eligible until granted
            ie = i_req && !i_granted;
            de = d_req && !d_granted;
`ifdef MEM_ARB_RR_EN
            take_d = de && !(ie && m_last_d);
`else
            take_d = de;
`endif
            take_i = ie && !take_d;
            if (take_d) begin
                m_busy = 2; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata; m_sel = d_sel;
                d_granted = 1; m_last_d = 1;
            end else if (take_i) begin
                m_busy = 1; m_addr = i_addr; m_we = 0; m_sel = 4'hF;
                i_granted = 1; m_last_d = 0;
            end else begin
                m_busy = 0;
            end
        end
        m_i_ack = n_i_ack;
        m_d_ack = n_d_ack;
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        chk("mem_ce", mem_ce, m_busy != 0);
        if (m_busy != 0) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_sel", mem_sel, m_sel);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("i_ack", i_ack, m_i_ack);
        chk("d_ack", d_ack, m_d_ack);
        chk("i_rdata", i_rdata, m_i_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
        if (i_ack) i_ack_cyc = cyc;
        if (d_ack) begin d_ack_cyc = cyc; d_ack_cnt++; end
        if (mem_ce) ce_cnt++;
        agent_step();
        mem_step();
        #1;
        chk("stall_req", stall_req, (i_req & ~m_i_ack) | (d_req & ~m_d_ack));
        model_step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ce"}, mem_ce, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_sel"}, mem_sel, 0);
        chk({tag, "_iack"}, i_ack, 0);
        chk({tag, "_dack"}, d_ack, 0);
        chk({tag, "_irdata"}, i_rdata, 0);
        chk({tag, "_drdata"}, d_rdata, 0);
    endtask

    initial begin
        i_addr = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_sel = 0; mem_rdata = 0;
        model_reset();
        @(negedge clk); @(negedge clk); #1;
        chk_all_zero("por");
        rst_n = 1;

        // fetch from 0x4, zero-wait memory
        w_lo = 0; w_hi = 0; rd_fixed = 1; rd_val = 32'h3402_1100;
        i_force = 1; f_i_addr = 32'h4;
        cycle(); chk("t1_stall_T", stall_req, 1);
        cycle(); chk("t1_ce", mem_ce, 1); chk("t1_addr", mem_addr, 32'h4);
        chk("t1_sel", mem_sel, 4'hF); chk("t1_stall_T1", stall_req, 1);
        cycle(); chk("t1_ack", i_ack, 1); chk("t1_rdata", i_rdata, 32'h3402_1100);
        chk("t1_stall_T2", stall_req, 0);
        repeat (3) cycle();

        // data write with three wait cycles
        w_lo = 3; w_hi = 3; rd_val = 32'h5555_5555;
        d_force = 1; f_d_we = 1; f_d_addr = 32'h100; f_d_wdata = 32'hDEAD_BEEF; f_d_sel = 4'b0011;
        d_ack_cnt = 0; ce_cnt = 0;
        repeat (10) cycle();
        chk("t2_d_acks", d_ack_cnt, 1);
        chk("t2_ce_cycles", ce_cnt, 4);
        chk("t2_d_rdata", d_rdata, 0);

        // simultaneous reads, zero-wait
        w_lo = 0; w_hi = 0; rd_fixed = 0;
        i_force = 1; f_i_addr = 32'h40;
        d_force = 1; f_d_we = 0; f_d_addr = 32'h80; f_d_wdata = 0; f_d_sel = 4'hF;
        cycle(); t0 = cyc;
        repeat (5) cycle();
`ifndef MEM_ARB_RR_EN
        chk("t3_d_ack_at", d_ack_cyc - t0, 2);
        chk("t3_i_ack_at", i_ack_cyc - t0, 3);
`endif

        // reset in the middle of a data access
        w_lo = 5; w_hi = 5;
        d_force = 1; f_d_we = 1; f_d_addr = 32'h200; f_d_wdata = 32'h1234_5678; f_d_sel = 4'hF;
        repeat (3) cycle();
        chk("t4_pre_ce", mem_ce, 1);
        rst_n = 0; #1;
        chk_all_zero("t4_rst");
        @(posedge clk); @(negedge clk);
        model_reset();
        rst_n = 1;
        d_ack_cnt = 0; w_lo = 0; w_hi = 0;
        repeat (8) cycle();
        chk("t4_no_ack", d_ack_cnt, 0);
        d_force = 1; f_d_we = 0; f_d_addr = 32'h300; f_d_sel = 4'hF;
        repeat (4) cycle();
        chk("t4_regrant_ack", d_ack_cnt, 1);

        // continuous data traffic against a held fetch request
        i_prob = 100; d_prob = 100;
        repeat (40) cycle();
        i_prob = 0; d_prob = 0;
        repeat (10) cycle();

        // random traffic, random wait states, stray ready while idle
        i_prob = 30; d_prob = 30; w_lo = 0; w_hi = 3; stray = 1;
        repeat (3000) cycle();
        i_prob = 0; d_prob = 0;
        repeat (30) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter that shares one single-port memory between the CPU's instruction-fetch port (I) and data-access port (D). It sits between the openmips core and the unified memory inside top. It serialises accesses through a small FSM, returns read data with a one-cycle ack pulse, and raises a stall request to the pipeline controller while any requester is waiting.

## Interface
- AW, 32, address width
- DW, 32, data width; byte-select width is DW/8
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  AW  fetch address
- i_ack  out  1  one-cycle completion pulse
- i_rdata  out  DW  fetched word, registered
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_sel  in  DW/8  byte enables
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  DW  read data, registered
- mem_ce  out  1  memory access active
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_sel  out  DW/8  memory byte enables; all ones for fetches
- mem_rdata  in  DW  memory read data, valid when mem_ready
- mem_ready  in  1  memory completes the current access this cycle
- stall_req  out  1  to pipeline control: a requester is waiting

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- Arbitration point: any cycle in IDLE, or the cycle in BUSY_x where mem_ready=1.
- At an arbitration point, eligible requesters are those with req=1 that are not acked in the current cycle. The winner's fields are registered onto the mem_* outputs, and the FSM enters BUSY_winner. With no eligible requester, the FSM goes to IDLE and mem_ce=0.
- Priority is fixed, D over I, unless changed under Configuration.
- BUSY_x: mem_ce=1, and the mem_* outputs stay stable until mem_ready.
- mem_ready=1 in BUSY_x: the next cycle pulses x_ack=1 for exactly one cycle.
  - On a read, x_rdata is loaded from mem_rdata.
  - On a D write, d_rdata keeps its previous value.
- The requester must drop req, or present a new request, in the cycle after ack. Because a requester's req is still high during its own ack cycle, the port being acked is excluded from the arbitration point that coincides with its ack. This prevents a double grant.
- Request fields are sampled only at grant. Changes while BUSY are ignored.
- The rdata outputs hold until the next read completion on the same port.
- stall_req = (i_req & ~i_ack) | (d_req & ~d_ack), combinational.
- mem_ready outside BUSY is ignored.
- Reset (rst=0, any time, including mid-access):
  - State goes to IDLE.
  - mem_ce, mem_we, i_ack and d_ack go to 0.
  - mem_addr, mem_wdata, mem_sel, i_rdata and d_rdata go to 0.
  - Any in-flight access is abandoned and never acked.

## Timing
- Request seen at cycle T in IDLE: mem_ce=1 from T+1.
- mem_ready at cycle R gives ack plus rdata at R+1.
- Zero-wait memory (mem_ready=1 in the first BUSY cycle): 2 cycles from req to ack.
- Back-to-back accesses: when the other requester is pending at cycle R, mem_ce stays 1 at R+1 with the new address. There are no idle bubbles between grants.
- Throughput with zero-wait memory: one access per cycle when both ports alternate.

## Configuration
- MEM_ARB_RR_EN undefined: fixed priority, D always wins a simultaneous contest. I can be delayed indefinitely by continuous D traffic.
- MEM_ARB_RR_EN defined: round robin.
  - A 1-bit last-grant register selects the port not most recently granted when both are eligible.
  - Its reset value is "I last", so D wins the first contest.
  - It updates on every grant.
  - With a single eligible requester, that requester is granted regardless of the pointer.

## Test plan
- Reset asserted mid-access (BUSY_D, mem_ce=1) -> all outputs 0 within the same cycle, no d_ack after release, next grant starts from IDLE.
- I read from 0x00000004, zero-wait memory returning 0x34021100 -> mem_ce=1 at T+1 with mem_addr=0x4 and mem_sel=4'hF; i_ack pulse at T+2 with i_rdata=0x34021100; stall_req=1 at T and T+1, 0 at T+2.
- D write to 0x00000100, d_wdata=0xDEADBEEF, d_sel=4'b0011, memory with 3 wait cycles -> mem_we/addr/wdata/sel stable for 3 cycles; single d_ack; d_rdata unchanged.
- i_req and d_req rise together, both reads, zero-wait, fixed priority -> D granted first, I granted in D's ready cycle; d_ack at T+2, i_ack at T+3; mem_ce continuously 1 from T+1 to T+2.
- Continuous D requests, each re-asserted the cycle after ack, plus a held i_req -> without MEM_ARB_RR_EN, I is granted only in a cycle with no eligible D; with MEM_ARB_RR_EN, grants alternate D, I, D, I.
- Requester holds req through its own ack cycle -> exactly one ack per request, no duplicate mem_ce grant to the same address.
